// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA modular exponentiation engine.
// Register-select codes, FSM states and the default key width.
package rsa_pkg;

    localparam int KEY_W_DEF = 256;

    localparam logic [1:0] SEL_NONE = 2'd0;
    localparam logic [1:0] SEL_M    = 2'd1;
    localparam logic [1:0] SEL_E    = 2'd2;
    localparam logic [1:0] SEL_N    = 2'd3;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CHECK,
        ST_LAUNCH,
        ST_MULT,
        ST_FIN,
        ST_ERR
    } state_t;

endpackage

// File: rtl/rsa_modmul.sv
// Bit-serial MSB-first interleaved modular multiplier: p = a*b mod n.
// Busy for KEY_W cycles after start; result valid the cycle busy drops.
module rsa_modmul #(
    parameter int KEY_W = 256
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [KEY_W-1:0] a,
    input  logic [KEY_W-1:0] b,
    input  logic [KEY_W-1:0] n,
    output logic             busy,
    output logic [KEY_W-1:0] p
);

    localparam int CW = $clog2(KEY_W);

    logic [KEY_W-1:0] a_sh;
    logic [KEY_W-1:0] b_q;
    logic [KEY_W-1:0] n_q;
    logic [CW-1:0]    cnt;
    logic [KEY_W:0]   dbl;
    logic [KEY_W-1:0] dbl_r;
    logic [KEY_W:0]   sum;
    logic [KEY_W-1:0] p_nxt;

    // p < n on entry, so 2p and (2p mod n) + b both stay below 2n
    always_comb begin
        dbl   = {p, 1'b0};
        dbl_r = KEY_W'((dbl >= {1'b0, n_q}) ? dbl - {1'b0, n_q} : dbl);
        sum   = {1'b0, dbl_r} + {1'b0, (a_sh[KEY_W-1] ? b_q : '0)};
        p_nxt = KEY_W'((sum >= {1'b0, n_q}) ? sum - {1'b0, n_q} : sum);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            busy <= 1'b0;
            cnt  <= '0;
            a_sh <= '0;
            b_q  <= '0;
            n_q  <= '0;
            p    <= '0;
        end else if (start && !busy) begin
            busy <= 1'b1;
            cnt  <= '0;
            a_sh <= a;
            b_q  <= b;
            n_q  <= n;
            p    <= '0;
        end else if (busy) begin
            p    <= p_nxt;
            a_sh <= a_sh << 1;
            cnt  <= cnt + CW'(1);
            if (cnt == CW'(KEY_W - 1))
                busy <= 1'b0;
        end
    end

endmodule

// File: rtl/rsa_modexp_engine.sv
// Byte-addressed RSA engine computing S = M^E mod N with
// right-to-left binary exponentiation over two parallel multipliers.
module rsa_modexp_engine
    import rsa_pkg::*;
#(
    parameter int KEY_W  = KEY_W_DEF,
    parameter int ADDR_W = $clog2(KEY_W / 8)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              we,
    input  logic              oe,
    input  logic              start,
    input  logic [1:0]        reg_sel,
    input  logic [ADDR_W-1:0] addr,
    input  logic [7:0]        data_i,
    output logic [7:0]        data_o,
    output logic              ready,
    output logic              done,
    output logic              error
);

    localparam int IW = $clog2(KEY_W);

    state_t           state;
    logic [KEY_W-1:0] m_r;
    logic [KEY_W-1:0] e_r;
    logic [KEY_W-1:0] n_r;
    logic [KEY_W-1:0] s_r;
    logic [KEY_W-1:0] r_r;
    logic [KEY_W-1:0] b_r;
    logic [KEY_W-1:0] r_p;
    logic [KEY_W-1:0] b_p;
    logic [IW-1:0]    idx;
    logic             r_busy;
    logic             b_busy;
    logic             launch;
    logic             bad;
    logic             wr;

    assign launch = (state == ST_LAUNCH);
    assign bad    = !n_r[0] || (n_r <= KEY_W'(1)) || (m_r >= n_r);
    // a start in the same cycle wins over a write
    assign wr     = ready && we && !start;

    rsa_modmul #(.KEY_W(KEY_W)) u_mul_r (
        .clk   (clk),
        .reset (reset),
        .start (launch),
        .a     (r_r),
        .b     (b_r),
        .n     (n_r),
        .busy  (r_busy),
        .p     (r_p)
    );

    rsa_modmul #(.KEY_W(KEY_W)) u_mul_b (
        .clk   (clk),
        .reset (reset),
        .start (launch),
        .a     (b_r),
        .b     (b_r),
        .n     (n_r),
        .busy  (b_busy),
        .p     (b_p)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_r <= '0;
            e_r <= '0;
            n_r <= '0;
        end else if (wr) begin
            unique case (reg_sel)
                SEL_M:   m_r[8*addr +: 8] <= data_i;
                SEL_E:   e_r[8*addr +: 8] <= data_i;
                SEL_N:   n_r[8*addr +: 8] <= data_i;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            data_o <= '0;
        else if (ready && oe)
            data_o <= s_r[8*addr +: 8];
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
            ready <= 1'b1;
            done  <= 1'b0;
            error <= 1'b0;
            s_r   <= '0;
            r_r   <= '0;
            b_r   <= '0;
            idx   <= '0;
        end else begin
            done <= 1'b0;
            unique case (state)
                ST_IDLE: begin
                    if (start) begin
                        ready <= 1'b0;
                        state <= ST_CHECK;
                    end
                end
                ST_CHECK: begin
                    error <= bad;
                    if (bad) begin
                        s_r   <= '0;
                        done  <= 1'b1;
                        state <= ST_ERR;
                    end else begin
                        r_r   <= KEY_W'(1);
                        b_r   <= m_r;
                        idx   <= '0;
                        state <= ST_LAUNCH;
                    end
                end
                ST_LAUNCH: state <= ST_MULT;
                ST_MULT: begin
                    if (!r_busy && !b_busy) begin
                        b_r <= b_p;
                        if (e_r[idx])
                            r_r <= r_p;
                        if (idx == IW'(KEY_W - 1)) begin
                            done  <= 1'b1;
                            state <= ST_FIN;
                        end else begin
                            idx   <= idx + IW'(1);
                            state <= ST_LAUNCH;
                        end
                    end
                end
                ST_FIN: begin
                    s_r   <= r_r;
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                ST_ERR: begin
                    ready <= 1'b1;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
